gcm_block_sequencer: RTL and testbench

- Per-worker block sequencer at the head of the AES-GCM pipeline, ahead of the key-expansion and encryption stages.
- Latches one instance descriptor: IV, AAD bit length, text bit length.
- Walks its strided share of the instance's block index space: AAD blocks, then text blocks, then the final length block. Worker i owns indices i, i+NUM_WORKERS, i+2·NUM_WORKERS, ...
- Successor to the fixed 4-worker stage-1 counter: adds parametrised worker count and widths, a valid/ready handshake, partial-block byte counts, a length-block phase, and GCM counter-block generation.

---
 rtl/gcm_block_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_gcm_block_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_block_sequencer.sv
// Per-worker AES-GCM block sequencer.
// Latches one instance descriptor (IV, AAD bit length, text bit length). It then
// walks this worker's strided share of the block index space: AAD blocks, then
// text blocks, then the final length block. Each block is offered downstream
// through a valid/ready handshake. Text blocks carry a GCM counter block
// IV || (k+2); the other phases carry a zero counter.
module gcm_block_sequencer #(
  parameter int NUM_WORKERS = 4,
  parameter int ID_W        = 2,
  parameter int LEN_W       = 64,
  parameter int IDX_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    i_id,
  input  logic               i_new_instance,
  input  logic [95:0]        i_iv,
  input  logic [LEN_W-1:0]   i_aad_len,
  input  logic [LEN_W-1:0]   i_pt_len,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [IDX_W-1:0]   o_idx,
  output logic [127:0]       o_counter,
  output logic [2:0]         o_phase,
  output logic [4:0]         o_bytes,
  output logic               o_done
);

  // S_RESTART is the single bubble cycle after an abort. During it o_valid is low
  // and the freshly latched descriptor is waiting to be started.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LEN,
    S_FLUSH,
    S_RESTART
  } state_t;

  // Everything registered per cycle: next FSM state plus every output field.
  typedef struct packed {
    state_t             state;
    logic               valid;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   idx;
    logic [127:0]       counter;
    logic [2:0]         phase;
    logic [4:0]         bytes;
  } step_t;

  localparam logic [2:0] PH_AAD   = 3'b010;
  localparam logic [2:0] PH_FIRST = 3'b000;
  localparam logic [2:0] PH_MID   = 3'b001;
  localparam logic [2:0] PH_LAST  = 3'b011;
  localparam logic [2:0] PH_SOLE  = 3'b111;
  localparam logic [2:0] PH_LEN   = 3'b101;
  localparam logic [2:0] PH_IDLE  = 3'b100;

  localparam logic [IDX_W-1:0] STRIDE    = IDX_W'(NUM_WORKERS);
  // NUM_WORKERS is a power of two, so "mod NUM_WORKERS" reduces to a mask.
  localparam logic [IDX_W-1:0] LANE_MASK = IDX_W'(NUM_WORKERS - 1);

  // Number of 128-bit blocks covering len bits: ceil(len/128), overflow-free.
  function automatic logic [IDX_W-1:0] ceil_blocks(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] q;
    q = (len >> 7) + LEN_W'(|len[6:0]);
    return IDX_W'(q);
  endfunction

  // Byte count of a final partial block: (len/8) mod 16, where 0 means a full block.
  function automatic logic [4:0] tail_bytes(input logic [3:0] r);
    return (r == 4'd0) ? 5'd16 : {1'b0, r};
  endfunction

  function automatic step_t idle_step();
    step_t s;
    s.state   = S_IDLE;
    s.valid   = 1'b0;
    s.busy    = 1'b0;
    s.done    = 1'b0;
    s.idx     = '0;
    s.counter = '0;
    s.phase   = PH_IDLE;
    s.bytes   = 5'd0;
    return s;
  endfunction

  function automatic step_t flush_step();
    step_t s;
    s       = idle_step();
    s.state = S_FLUSH;
    s.done  = 1'b1;
    return s;
  endfunction

  function automatic step_t bubble_step();
    step_t s;
    s       = idle_step();
    s.state = S_RESTART;
    s.busy  = 1'b1;
    return s;
  endfunction

  // Decides what happens at block index idx. If idx is still inside the
  // instance, the result is a data block. Otherwise it is the length block when
  // this worker owns index `total`, and the done flush when it does not.
  function automatic step_t plan(
    input logic [IDX_W-1:0] idx,
    input logic [IDX_W-1:0] a,
    input logic [IDX_W-1:0] t,
    input logic [IDX_W-1:0] total,
    input logic [3:0]       aad_tail,
    input logic [3:0]       pt_tail,
    input logic [95:0]      iv,
    input logic [ID_W-1:0]  id
  );
    step_t            s;
    logic [IDX_W-1:0] k;
    s = idle_step();
    k = idx - a;
    if (idx < total) begin
      s.state = S_RUN;
      s.valid = 1'b1;
      s.busy  = 1'b1;
      s.idx   = idx;
      if (idx < a) begin
        s.phase = PH_AAD;
        s.bytes = (idx == a - IDX_W'(1)) ? tail_bytes(aad_tail) : 5'd16;
      end else begin
        s.counter = {iv, 32'(k + IDX_W'(2))};
        if (t == IDX_W'(1))             s.phase = PH_SOLE;
        else if (k == '0)               s.phase = PH_FIRST;
        else if (k == t - IDX_W'(1))    s.phase = PH_LAST;
        else                            s.phase = PH_MID;
        s.bytes = (k == t - IDX_W'(1)) ? tail_bytes(pt_tail) : 5'd16;
      end
    end else if ((total & LANE_MASK) == IDX_W'(id)) begin
      s.state = S_LEN;
      s.valid = 1'b1;
      s.busy  = 1'b1;
      s.idx   = total;
      s.phase = PH_LEN;
      s.bytes = 5'd16;
    end else begin
      s = flush_step();
    end
    return s;
  endfunction

  step_t            out_q;
  logic [95:0]      iv_q;
  logic [IDX_W-1:0] a_q, t_q, total_q;
  logic [3:0]       aad_tail_q, pt_tail_q;

  logic [IDX_W-1:0] in_a, in_t, in_total;
  logic             load;
  step_t            start_step, adv_step;

  // Derived block counts of the incoming descriptor, plus the candidate next steps.
  // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
  always_comb begin
    in_a     = ceil_blocks(i_aad_len);
    in_t     = ceil_blocks(i_pt_len);
    in_total = in_a + in_t;
    // A start pulse is taken everywhere except the one-cycle done flush.
    load     = i_new_instance && (out_q.state != S_FLUSH);
    if (out_q.state == S_IDLE) begin
      start_step = plan(IDX_W'(i_id), in_a, in_t, in_total,
                        i_aad_len[6:3], i_pt_len[6:3], i_iv, i_id);
    end else begin
      start_step = plan(IDX_W'(i_id), a_q, t_q, total_q,
                        aad_tail_q, pt_tail_q, iv_q, i_id);
    end
    adv_step = plan(out_q.idx + STRIDE, a_q, t_q, total_q,
                    aad_tail_q, pt_tail_q, iv_q, i_id);
  end

  // Latch the instance descriptor whenever a start pulse is taken.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q       <= '0;
      a_q        <= '0;
      t_q        <= '0;
      total_q    <= '0;
      aad_tail_q <= '0;
      pt_tail_q  <= '0;
    end else if (load) begin
      iv_q       <= i_iv;
      a_q        <= in_a;
      t_q        <= in_t;
      total_q    <= in_total;
      aad_tail_q <= i_aad_len[6:3];
      pt_tail_q  <= i_pt_len[6:3];
    end
  end

  // Sequencer FSM with registered outputs. Outputs only change on accept, start,
  // abort or flush, so they stay stable while a block is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= idle_step();
    end else begin
      unique case (out_q.state)
        S_IDLE: begin
          if (i_new_instance) out_q <= start_step;
        end
        S_RUN: begin
          if (i_new_instance) out_q <= bubble_step();
          else if (i_ready)   out_q <= adv_step;
        end
        S_LEN: begin
          if (i_new_instance) out_q <= bubble_step();
          else if (i_ready)   out_q <= flush_step();
        end
        S_FLUSH: begin
          out_q <= idle_step();
        end
        S_RESTART: begin
          if (i_new_instance) out_q <= bubble_step();
          else                out_q <= start_step;
        end
        default: begin
          out_q <= idle_step();
        end
      endcase
    end
  end

  assign o_valid   = out_q.valid;
  assign o_busy    = out_q.busy;
  assign o_done    = out_q.done;
  assign o_idx     = out_q.idx;
  assign o_counter = out_q.counter;
  assign o_phase   = out_q.phase;
  assign o_bytes   = out_q.bytes;

endmodule

// File: tb/tb_gcm_block_sequencer.sv
// Scoreboard bench for gcm_block_sequencer. The reference model lists the
// blocks a worker must emit by plain integer arithmetic over the descriptor,
// and a negedge monitor pops and compares every accepted block.
module tb_gcm_block_sequencer;

  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   i_id = '0;
  logic         i_new_instance = 1'b0;
  logic [95:0]  i_iv = '0;
  logic [63:0]  i_aad_len = '0;
  logic [63:0]  i_pt_len = '0;
  logic         i_ready = 1'b0;
  logic         o_busy, o_valid, o_done;
  logic [31:0]  o_idx;
  logic [127:0] o_counter;
  logic [2:0]   o_phase;
  logic [4:0]   o_bytes;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0]  idx;
    logic [2:0]   phase;
    logic [127:0] counter;
    logic [4:0]   bytes;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic         prev_stall = 1'b0;
  logic         prev_new = 1'b0;
  logic [31:0]  prev_idx;
  logic [127:0] prev_counter;
  logic [2:0]   prev_phase;
  logic [4:0]   prev_bytes;

  gcm_block_sequencer #(
    .NUM_WORKERS(NW), .ID_W(2), .LEN_W(64), .IDX_W(32)
  ) dut (
    .clk(clk), .rst(rst), .i_id(i_id), .i_new_instance(i_new_instance),
    .i_iv(i_iv), .i_aad_len(i_aad_len), .i_pt_len(i_pt_len),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
    .o_idx(o_idx), .o_counter(o_counter), .o_phase(o_phase),
    .o_bytes(o_bytes), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the block list for one worker, taken straight from the GCM layout.
  function automatic void build_expected(input int id, input longint aad, input longint pt,
                                         input logic [95:0] iv);
    longint a, t, total, k, r;
    exp_t   e;
    a     = (aad + 127) / 128;
    t     = (pt + 127) / 128;
    total = a + t;
    for (longint idx = id; idx < total; idx += NW) begin
      e.idx = 32'(idx);
      if (idx < a) begin
        e.phase   = 3'b010;
        e.counter = '0;
        r         = (aad / 8) % 16;
        e.bytes   = (idx == a - 1) ? ((r == 0) ? 5'd16 : 5'(r)) : 5'd16;
      end else begin
        k = idx - a;
        if (t == 1)          e.phase = 3'b111;
        else if (k == 0)     e.phase = 3'b000;
        else if (k == t - 1) e.phase = 3'b011;
        else                 e.phase = 3'b001;
        e.counter = {iv, 32'(k + 2)};
        r         = (pt / 8) % 16;
        e.bytes   = (k == t - 1) ? ((r == 0) ? 5'd16 : 5'(r)) : 5'd16;
      end
      exp_q.push_back(e);
    end
    if ((total % NW) == id) begin
      e.idx     = 32'(total);
      e.phase   = 3'b101;
      e.counter = '0;
      e.bytes   = 5'd16;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compare accepted blocks, check stall stability, count done pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_new   = 1'b0;
    end else begin
      if (prev_stall && !prev_new) begin
        check("stall_valid", o_valid, 1'b1);
        check("stall_idx", o_idx, prev_idx);
        check("stall_phase", o_phase, prev_phase);
        check("stall_counter", o_counter, prev_counter);
        check("stall_bytes", o_bytes, prev_bytes);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_block", o_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("blk_idx", o_idx, mon_e.idx);
          check("blk_phase", o_phase, mon_e.phase);
          check("blk_counter", o_counter, mon_e.counter);
          check("blk_bytes", o_bytes, mon_e.bytes);
          check("blk_busy", o_busy, 1'b1);
        end
      end
      if (o_done) begin
        done_cnt++;
        check("done_quiet", {o_valid, o_busy}, 2'b00);
      end
      prev_stall   = o_valid && !i_ready;
      prev_new     = i_new_instance;
      prev_idx     = o_idx;
      prev_phase   = o_phase;
      prev_counter = o_counter;
      prev_bytes   = o_bytes;
    end
  end

  task automatic check_reset_outputs();
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_idx", o_idx, 32'd0);
    check("rst_counter", o_counter, 128'd0);
    check("rst_phase", o_phase, 3'b100);
    check("rst_bytes", o_bytes, 5'd0);
  endtask

  // Issue a start pulse (called at posedge+1); ready is held low during the pulse.
  task automatic start_instance(input int id, input longint aad, input longint pt,
                                input logic [95:0] iv);
    exp_q.delete();
    build_expected(id, aad, pt, iv);
    i_id           = 2'(id);
    i_aad_len      = 64'(aad);
    i_pt_len       = 64'(pt);
    i_iv           = iv;
    i_new_instance = 1'b1;
    i_ready        = 1'b0;
    @(posedge clk); #1;
    i_new_instance = 1'b0;
  endtask

  // Drive ready until o_done. Mode 0: always ready, 1: random, 2: three stalls then ready.
  task automatic run_to_done(input int mode, input int done_before);
    int           cyc = 0;
    bit           seen = 0;
    logic [31:0]  idx0 = '0;
    logic [2:0]   ph0 = '0;
    logic [127:0] ctr0 = '0;
    while (!seen && cyc < 600) begin
      if (o_done) begin
        seen = 1;
      end else begin
        if (mode == 2 && cyc == 0) begin
          idx0 = o_idx; ph0 = o_phase; ctr0 = o_counter;
        end
        if (mode == 2 && cyc == 3) begin
          check("hold_valid", o_valid, 1'b1);
          check("hold_idx", o_idx, idx0);
          check("hold_phase", o_phase, ph0);
          check("hold_counter", o_counter, ctr0);
        end
        if (mode == 0)      i_ready = 1'b1;
        else if (mode == 1) i_ready = ($urandom_range(0, 3) != 0);
        else                i_ready = (cyc >= 3);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_valid_low", o_valid, 1'b0);
    i_ready = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", o_done, 1'b0);
    check("busy_after_done", o_busy, 1'b0);
    check("done_count", done_cnt, done_before + 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int           db;
    bit           found;
    logic [95:0]  iv_a, iv_b;

    // Reset overrides a simultaneous start pulse.
    rst = 1'b1; i_new_instance = 1'b1; i_aad_len = 64'd256; i_pt_len = 64'd512;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0; i_new_instance = 1'b0;
    @(posedge clk); #1;
    check("idle_no_start", o_busy, 1'b0);

    iv_a = {32'hcafebabe, 32'h01234567, 32'h89abcdef};
    iv_b = {32'h0badf00d, 32'h55aa55aa, 32'h13579bdf};

    // Same instance across all four workers, downstream always ready.
    for (int id = 0; id < NW; id++) begin
      db = done_cnt;
      start_instance(id, 256, 512, iv_a);
      run_to_done(0, db);
    end

    // Single partial text block, and the zero-length instance.
    for (int id = 0; id < 2; id++) begin
      db = done_cnt;
      start_instance(id, 0, 40, iv_b);
      run_to_done(0, db);
      db = done_cnt;
      start_instance(id, 0, 0, iv_b);
      run_to_done(0, db);
    end

    // AAD only, with a partial last AAD block.
    db = done_cnt;
    start_instance(3, 8 * 37, 0, iv_a);
    run_to_done(0, db);

    // Stall for three cycles at the first block.
    db = done_cnt;
    start_instance(0, 256, 512, iv_a);
    run_to_done(2, db);

    // Abort mid-run with a new IV: one bubble cycle, then restart, with a single done.
    db = done_cnt;
    start_instance(0, 512, 1024, iv_a);
    i_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort_pre_busy", o_busy, 1'b1);
    start_instance(0, 256, 384, iv_b);
    check("abort_bubble_valid", o_valid, 1'b0);
    check("abort_bubble_busy", o_busy, 1'b1);
    run_to_done(0, db);

    // Reset while a length block is stalled.
    db = done_cnt;
    start_instance(2, 256, 512, iv_a);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (o_valid && o_phase == 3'b101) begin
        found = 1;
      end else begin
        i_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    i_ready = 1'b0;
    check("len_reached", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs();
    exp_q.delete();
    @(posedge clk); #1;
    check("post_rst_idle_busy", o_busy, 1'b0);
    check("post_rst_idle_valid", o_valid, 1'b0);
    check("post_rst_no_done", done_cnt, db);

    // Randomized instances with random backpressure.
    for (int n = 0; n < 40; n++) begin
      db = done_cnt;
      start_instance(int'($urandom_range(0, NW - 1)),
                     longint'($urandom_range(0, 80)) * 8,
                     longint'($urandom_range(0, 160)) * 8,
                     {$urandom, $urandom, $urandom});
      run_to_done(1, db);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
